// File: rtl/cache_write_interface.sv
`default_nettype none
// ============================================================================
// Module   : cache_write_interface
// Purpose  : Splits IWIDTH stream beats into CWIDTH cache-SRAM writes under a
//            two-entry header queue; pulses completion on each final word.
// Revision : 1.0
// ============================================================================
module cache_write_interface #(
  parameter int ADDR_BITS  = 10,
  parameter int LEN_BITS   = 8,
  parameter int IWIDTH     = 128,
  parameter int CWIDTH     = 32,
  parameter int BUF_LEN    = 4,
  parameter int ID_LEN     = 2,
  parameter int CL_WORDS_E = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  output logic                 OUT_ready,
  input  logic                 IN_valid,
  input  logic [ID_LEN-1:0]    IN_id,
  input  logic [ADDR_BITS-1:0] IN_addr,
  input  logic [LEN_BITS-1:0]  IN_len,
  input  logic                 IN_dataValid,
  output logic                 OUT_dataReady,
  input  logic [IWIDTH-1:0]    IN_data,
  input  logic                 IN_CACHE_ready,
  output logic                 OUT_CACHE_ce,
  output logic                 OUT_CACHE_we,
  output logic [ADDR_BITS-1:0] OUT_CACHE_addr,
  output logic [CWIDTH-1:0]    OUT_CACHE_data,
  output logic                 OUT_cacheWriteValid,
  output logic [ID_LEN-1:0]    OUT_cacheWriteId
);

  localparam int C_WNUM  = IWIDTH / CWIDTH;
  localparam int C_SUB_W = (C_WNUM > 1) ? $clog2(C_WNUM) : 1;
  localparam int C_PTR_W = (BUF_LEN > 1) ? $clog2(BUF_LEN) : 1;
  localparam int C_CW_E  = $clog2(CWIDTH / 32);
  localparam logic [LEN_BITS-1:0] C_STEP     = LEN_BITS'(CWIDTH / 32);
  localparam logic [C_SUB_W-1:0]  C_SUB_LAST = C_SUB_W'(C_WNUM - 1);
  localparam logic [C_PTR_W:0]    C_FULL     = (C_PTR_W + 1)'(BUF_LEN);

  logic                 r_cur_valid, r_nxt_valid;
  logic [ID_LEN-1:0]    r_cur_id, r_nxt_id;
  logic [ADDR_BITS-1:0] r_cur_addr, r_nxt_addr;
  logic [LEN_BITS-1:0]  r_cur_len, r_nxt_len;

  logic [IWIDTH-1:0]    r_mem [BUF_LEN];
  logic [C_PTR_W-1:0]   r_wr_ptr, r_rd_ptr;
  logic [C_PTR_W:0]     r_count;
  logic [C_SUB_W-1:0]   r_sub_idx;
  logic [LEN_BITS-1:0]  r_progress;

  logic [C_WNUM-1:0][CWIDTH-1:0] w_head;
  logic w_issue, w_write_succ, w_last_word, w_pop, w_push, w_done, w_hdr_acc;

  assign w_head       = r_mem[r_rd_ptr];
  assign w_issue      = r_cur_valid && (r_count != '0);
  assign w_write_succ = w_issue && IN_CACHE_ready;
  assign w_last_word  = r_progress[LEN_BITS-1:C_CW_E] == r_cur_len[LEN_BITS-1:C_CW_E];
  assign w_done       = w_write_succ && w_last_word;
  // A partial final beat is released as soon as its last used word lands.
  assign w_pop        = w_write_succ && ((r_sub_idx == C_SUB_LAST) || w_last_word);

  assign OUT_ready     = !r_nxt_valid || w_done;
  assign OUT_dataReady = r_count != C_FULL;
  assign w_hdr_acc     = IN_valid && OUT_ready;
  assign w_push        = IN_dataValid && OUT_dataReady;

  assign OUT_CACHE_ce        = !w_issue;
  assign OUT_CACHE_we        = !w_issue;
  assign OUT_CACHE_data      = w_head[r_sub_idx];
  assign OUT_CACHE_addr      = {r_cur_addr[ADDR_BITS-1:CL_WORDS_E],
                                r_cur_addr[CL_WORDS_E-1:0] + r_progress[CL_WORDS_E-1:0]};
  assign OUT_cacheWriteValid = w_done;
  assign OUT_cacheWriteId    = r_cur_id;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cur_valid <= 1'b0;
      r_cur_id    <= '0;
      r_cur_addr  <= '0;
      r_cur_len   <= '0;
      r_nxt_valid <= 1'b0;
      r_nxt_id    <= '0;
      r_nxt_addr  <= '0;
      r_nxt_len   <= '0;
    end else if (w_done) begin
      if (r_nxt_valid) begin
        r_cur_id    <= r_nxt_id;
        r_cur_addr  <= r_nxt_addr;
        r_cur_len   <= r_nxt_len;
        r_nxt_valid <= w_hdr_acc;
        if (w_hdr_acc) begin
          r_nxt_id   <= IN_id;
          r_nxt_addr <= IN_addr;
          r_nxt_len  <= IN_len;
        end
      end else begin
        r_cur_valid <= w_hdr_acc;
        if (w_hdr_acc) begin
          r_cur_id   <= IN_id;
          r_cur_addr <= IN_addr;
          r_cur_len  <= IN_len;
        end
      end
    end else if (w_hdr_acc) begin
      if (!r_cur_valid) begin
        r_cur_valid <= 1'b1;
        r_cur_id    <= IN_id;
        r_cur_addr  <= IN_addr;
        r_cur_len   <= IN_len;
      end else begin
        r_nxt_valid <= 1'b1;
        r_nxt_id    <= IN_id;
        r_nxt_addr  <= IN_addr;
        r_nxt_len   <= IN_len;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_sub_idx  <= '0;
      r_progress <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + C_PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + C_PTR_W'(1);
      r_count <= r_count + {{C_PTR_W{1'b0}}, w_push} - {{C_PTR_W{1'b0}}, w_pop};
      if (w_write_succ) begin
        r_sub_idx  <= w_pop  ? '0 : r_sub_idx + C_SUB_W'(1);
        r_progress <= w_done ? '0 : r_progress + C_STEP;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= IN_data;
  end

endmodule
`default_nettype wire

// File: tb/tb_cache_write_interface.sv
`default_nettype none
// Bench for cache_write_interface: directed scenarios plus randomized traffic,
// checked every cycle against a transaction-level model of expected writes.
module tb_cache_write_interface;
  localparam int AW = 10, LW = 8, IW = 128, CW = 32, BL = 4, IDW = 2, WN = IW / CW;

  typedef struct {
    logic [AW-1:0]  addr;
    logic [CW-1:0]  data;
    bit             last;
    bit             pop;
    logic [IDW-1:0] id;
  } wr_t;

  logic clk = 1'b0, rst = 1'b1;
  logic IN_valid = 1'b0, IN_dataValid = 1'b0, IN_CACHE_ready = 1'b0;
  logic [IDW-1:0] IN_id = '0;
  logic [AW-1:0]  IN_addr = '0;
  logic [LW-1:0]  IN_len = '0;
  logic [IW-1:0]  IN_data = '0;
  logic OUT_ready, OUT_dataReady, OUT_CACHE_ce, OUT_CACHE_we, OUT_cacheWriteValid;
  logic [AW-1:0]  OUT_CACHE_addr;
  logic [CW-1:0]  OUT_CACHE_data;
  logic [IDW-1:0] OUT_cacheWriteId;

  cache_write_interface dut (
    .clk(clk), .rst(rst), .OUT_ready(OUT_ready), .IN_valid(IN_valid), .IN_id(IN_id),
    .IN_addr(IN_addr), .IN_len(IN_len), .IN_dataValid(IN_dataValid),
    .OUT_dataReady(OUT_dataReady), .IN_data(IN_data), .IN_CACHE_ready(IN_CACHE_ready),
    .OUT_CACHE_ce(OUT_CACHE_ce), .OUT_CACHE_we(OUT_CACHE_we), .OUT_CACHE_addr(OUT_CACHE_addr),
    .OUT_CACHE_data(OUT_CACHE_data), .OUT_cacheWriteValid(OUT_cacheWriteValid),
    .OUT_cacheWriteId(OUT_cacheWriteId)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0, cyc = 0, ncompl = 0, n_hdr = 0, n_beat = 0;
  int m_pend = 0, m_occ = 0;
  int hdr_pct = 100, dat_pct = 100, rdy_pct = 100;
  logic [IDW+AW+LW-1:0] hdr_q[$];
  logic [IW-1:0]        beat_q[$];
  bit                   rdy_pat[$];
  wr_t                  exp_q[$];
  logic [AW-1:0]  l_addr[$];
  bit             l_done[$];
  logic [IDW-1:0] l_id[$];
  int             l_cyc[$];
  bit h_take = 1'b0, b_take = 1'b0;
  bit e_issue, e_commit, e_done, e_rdy, e_drdy;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Queue a transfer: its header, its beats, and every cache write it must produce.
  task automatic plan(input logic [IDW-1:0] id, input logic [AW-1:0] addr, input logic [LW-1:0] len);
    int nw, nb;
    logic [IW-1:0] b[$];
    logic [IW-1:0] beat;
    wr_t e;
    nw = int'(len) + 1;
    nb = (nw + WN - 1) / WN;
    hdr_q.push_back({id, addr, len});
    for (int i = 0; i < nb; i++) begin
      beat = {$urandom, $urandom, $urandom, $urandom};
      b.push_back(beat);
      beat_q.push_back(beat);
    end
    for (int k = 0; k < nw; k++) begin
      e.addr = {addr[AW-1:4], 4'(int'(addr[3:0]) + k)};
      e.data = b[k / WN][(k % WN) * CW +: CW];
      e.last = (k == nw - 1);
      e.pop  = ((k % WN) == WN - 1) || e.last;
      e.id   = id;
      exp_q.push_back(e);
    end
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || hdr_q.size() != 0 || beat_q.size() != 0) && n < budget) begin
      @(posedge clk);
      n++;
    end
    total++;
    if (n >= budget) begin
      bad++;
      $display("FAIL drain: %0d writes still outstanding after %0d cycles", exp_q.size(), budget);
    end
    repeat (2) @(posedge clk);
  endtask

  // Stimulus driver: drives just after posedge, notes handshakes at negedge.
  always begin
    @(posedge clk);
    #1;
    if (!rst) begin
      hdr_q.delete(); beat_q.delete(); rdy_pat.delete();
      IN_valid = 1'b0; IN_dataValid = 1'b0; IN_CACHE_ready = 1'b0;
    end else begin
      if (h_take) begin void'(hdr_q.pop_front()); IN_valid = 1'b0; end
      if (b_take) begin void'(beat_q.pop_front()); IN_dataValid = 1'b0; end
      if (!IN_valid && hdr_q.size() > 0 && $urandom_range(1, 100) <= hdr_pct) begin
        IN_valid = 1'b1;
        {IN_id, IN_addr, IN_len} = hdr_q[0];
      end
      if (!IN_dataValid && beat_q.size() > 0 && $urandom_range(1, 100) <= dat_pct) begin
        IN_dataValid = 1'b1;
        IN_data = beat_q[0];
      end
      if (rdy_pat.size() > 0 && !OUT_CACHE_ce) IN_CACHE_ready = rdy_pat.pop_front();
      else IN_CACHE_ready = ($urandom_range(1, 100) <= rdy_pct);
    end
    @(negedge clk);
    h_take = rst && IN_valid && OUT_ready;
    b_take = rst && IN_dataValid && OUT_dataReady;
  end

  // Compare process: model state is pending headers, buffered beats, expected writes.
  always @(negedge clk) begin
    cyc++;
    if (!rst) begin
      chk("rst_ce", OUT_CACHE_ce, 1);
      chk("rst_we", OUT_CACHE_we, 1);
      chk("rst_ready", OUT_ready, 1);
      chk("rst_dready", OUT_dataReady, 1);
      chk("rst_wvalid", OUT_cacheWriteValid, 0);
      m_pend = 0; m_occ = 0; exp_q.delete();
    end else begin
      e_issue  = (m_pend > 0) && (m_occ > 0) && (exp_q.size() > 0);
      e_commit = e_issue && IN_CACHE_ready;
      e_done   = e_commit && exp_q[0].last;
      e_rdy    = (m_pend < 2) || e_done;
      e_drdy   = m_occ < BL;
      chk("ce", OUT_CACHE_ce, !e_issue);
      chk("we", OUT_CACHE_we, !e_issue);
      chk("ready", OUT_ready, e_rdy);
      chk("dready", OUT_dataReady, e_drdy);
      chk("wvalid", OUT_cacheWriteValid, e_done);
      if (e_issue) begin
        chk("addr", OUT_CACHE_addr, exp_q[0].addr);
        chk("data", OUT_CACHE_data, exp_q[0].data);
      end
      if (e_done) chk("wid", OUT_cacheWriteId, exp_q[0].id);
      if (OUT_cacheWriteValid === 1'b1) ncompl++;
      if (OUT_CACHE_ce === 1'b0 && IN_CACHE_ready) begin
        l_addr.push_back(OUT_CACHE_addr);
        l_done.push_back(OUT_cacheWriteValid === 1'b1);
        l_id.push_back(OUT_cacheWriteId);
        l_cyc.push_back(cyc);
      end
      if (e_commit) begin
        if (exp_q[0].pop) m_occ--;
        if (exp_q[0].last) m_pend--;
        void'(exp_q.pop_front());
      end
      if (IN_valid && e_rdy) begin m_pend++; n_hdr++; end
      if (IN_dataValid && e_drdy) begin m_occ++; n_beat++; end
    end
  end

  initial begin
    int base, c0, hb, bb, n;
    logic [AW-1:0] t2_addr [4];
    t2_addr = '{10'h04E, 10'h04F, 10'h040, 10'h041};
    #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;

    // Two full beats, consecutive writes, one completion.
    base = l_addr.size(); c0 = ncompl;
    plan(2'd1, 10'h040, 8'd7);
    drain(200);
    for (int i = 0; i < 8; i++) begin
      chk("t1_addr", l_addr[base+i], 10'h040 + i);
      chk("t1_done", l_done[base+i], i == 7);
    end
    chk("t1_span", l_cyc[base+7] - l_cyc[base], 7);
    chk("t1_id", l_id[base+7], 1);
    chk("t1_ncompl", ncompl - c0, 1);

    // Wrap inside the cache line.
    base = l_addr.size();
    plan(2'd2, 10'h04E, 8'd3);
    drain(200);
    for (int i = 0; i < 4; i++) chk("t2_addr", l_addr[base+i], t2_addr[i]);

    // Partial final beat.
    base = l_addr.size();
    plan(2'd3, 10'h100, 8'd5);
    drain(200);
    @(negedge clk); #1;
    chk("t3_count", l_addr.size() - base, 6);
    chk("t3_dready", OUT_dataReady, 1);
    chk("t3_ce_idle", OUT_CACHE_ce, 1);

    // Cache back-pressure on word 1.
    base = l_addr.size();
    rdy_pat = '{1'b1, 1'b0, 1'b0, 1'b1};
    plan(2'd0, 10'h200, 8'd3);
    drain(200);
    chk("t4_hold", l_cyc[base+1] - l_cyc[base], 3);
    chk("t4_count", l_addr.size() - base, 4);
    chk("t4_addr1", l_addr[base+1], 10'h201);

    // Data first, then back-to-back headers.
    base = l_addr.size(); hb = n_hdr; bb = n_beat;
    hdr_pct = 0;
    plan(2'd1, 10'h300, 8'd3);
    plan(2'd2, 10'h310, 8'd3);
    plan(2'd3, 10'h320, 8'd3);
    plan(2'd0, 10'h330, 8'd3);
    n = 0;
    while (n_beat < bb + 4 && n < 100) begin @(negedge clk); #1; n++; end
    @(negedge clk); #1;
    chk("t5_dready_full", OUT_dataReady, 0);
    hdr_pct = 100;
    n = 0;
    while (n_hdr < hb + 2 && n < 100) begin @(negedge clk); #1; n++; end
    @(negedge clk); #1;
    chk("t5_ready_low", OUT_ready, 0);
    drain(400);
    chk("t5_doneA", l_done[base+3], 1);
    chk("t5_idA", l_id[base+3], 1);
    chk("t5_idB", l_id[base+7], 2);
    chk("t5_gap", l_cyc[base+7] - l_cyc[base+3], 4);

    // Reset mid-transfer.
    base = l_addr.size(); c0 = ncompl;
    plan(2'd3, 10'h080, 8'd7);
    n = 0;
    while (l_addr.size() < base + 2 && n < 100) begin @(negedge clk); #1; n++; end
    @(posedge clk); #2 rst = 1'b0;
    #1;
    chk("t6_ce", OUT_CACHE_ce, 1);
    chk("t6_we", OUT_CACHE_we, 1);
    chk("t6_wvalid", OUT_cacheWriteValid, 0);
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    @(negedge clk); #1;
    chk("t6_no_pulse", ncompl - c0, 0);
    chk("t6_dready", OUT_dataReady, 1);
    plan(2'd1, 10'h0C0, 8'd3);
    drain(200);
    chk("t6_fresh", ncompl - c0, 1);
    chk("t6_last_addr", l_addr[l_addr.size()-1], 10'h0C3);

    // Randomized traffic.
    for (int ch = 0; ch < 4; ch++) begin
      hdr_pct = $urandom_range(30, 100);
      dat_pct = $urandom_range(30, 100);
      rdy_pct = $urandom_range(30, 100);
      for (int t = 0; t < 12; t++)
        plan(2'($urandom), 10'($urandom), 8'($urandom_range(0, 19)));
      drain(4000);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
